// File: rtl/detector_riesgos_if.sv
// -----------------------------------------------------------------------------
// detector_riesgos_if
//
// Bundles the signals exchanged between the pipeline and the hazard detector.
//
//   From the pipeline (master drives, slave reads):
//     RsId, RtId   [4:0] source register fields of the instruction in ID
//     UsaRt              ID instruction reads Rt as a source
//     RtEx         [4:0] destination register of the instruction in EX
//     LeeMemEx           EX instruction is a load
//     SaltoTomado        branch/jump resolved taken in EX
//     MultIni            a multiply leaves ID for EX this cycle
//   To the pipeline (slave drives, master reads):
//     EscPC              PC write enable
//     EscIfId            IF/ID write enable
//     BurbujaEx          force zero control into ID/EX
//     VaciarIfId         clear IF/ID to a NOP
//     Ocupado            a multiply is in flight
//     CiclosParo  [15:0] saturating count of stall cycles
// -----------------------------------------------------------------------------
interface detector_riesgos_if;
  logic [4:0]  RsId;
  logic [4:0]  RtId;
  logic        UsaRt;
  logic [4:0]  RtEx;
  logic        LeeMemEx;
  logic        SaltoTomado;
  logic        MultIni;

  logic        EscPC;
  logic        EscIfId;
  logic        BurbujaEx;
  logic        VaciarIfId;
  logic        Ocupado;
  logic [15:0] CiclosParo;

  modport master (
    output RsId, RtId, UsaRt, RtEx, LeeMemEx, SaltoTomado, MultIni,
    input  EscPC, EscIfId, BurbujaEx, VaciarIfId, Ocupado, CiclosParo
  );

  modport slave (
    input  RsId, RtId, UsaRt, RtEx, LeeMemEx, SaltoTomado, MultIni,
    output EscPC, EscIfId, BurbujaEx, VaciarIfId, Ocupado, CiclosParo
  );
endinterface

// File: rtl/detector_riesgos.sv
// -----------------------------------------------------------------------------
// detector_riesgos
//
// Hazard detection unit for a 5-stage pipeline with a multi-cycle multiplier.
//   - Load-use hazard: stall PC and IF/ID, insert a bubble into EX.
//   - Taken branch/jump: flush IF/ID and bubble EX; wins over every stall.
//   - Multiply: once accepted, stall the front end for LAT_MULT-1 cycles.
//   - Counts stall cycles (EscPC low) in a saturating 16-bit counter.
//
// Parameters:
//   LAT_MULT  multiply latency in cycles, legal range 2..16
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous, active-high
//   hz        detector_riesgos_if.slave, see interface header for signals
// -----------------------------------------------------------------------------
module detector_riesgos #(
  parameter int unsigned LAT_MULT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  detector_riesgos_if.slave        hz
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_MULT   = 1'b1;

  // Cuenta is loaded with the number of MULT cycles still to run; the state
  // is left on the edge where it reads 1, giving LAT_MULT-1 busy cycles.
  localparam logic [3:0] CUENTA_INI = 4'(LAT_MULT - 1);

  logic [0:0]  estado_q, estado_d;
  logic [3:0]  cuenta_q, cuenta_d;
  logic [15:0] ciclos_paro_q, ciclos_paro_d;

  logic rcarga;
  logic esc_pc;
  logic esc_ifid;
  logic burbuja_ex;
  logic vaciar_ifid;
  logic ocupado;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // Register 0 is hard-wired, so it never creates a dependency.
  always_comb begin
    rcarga = hz.LeeMemEx && (hz.RtEx != 5'd0) &&
             ((hz.RtEx == hz.RsId) || (hz.UsaRt && (hz.RtEx == hz.RtId)));
  end

  // Pipeline control outputs, in priority order: reset, flush, stall, run.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no
    // path through the block leaves a signal unassigned (no latch).
    esc_pc      = 1'b1;
    esc_ifid    = 1'b1;
    burbuja_ex  = 1'b0;
    vaciar_ifid = 1'b0;
    ocupado     = 1'b0;

    if (reset) begin
      esc_pc      = 1'b0;
      esc_ifid    = 1'b0;
      burbuja_ex  = 1'b1;
      vaciar_ifid = 1'b1;
    end else begin
      ocupado = (estado_q == ST_MULT);
      if (hz.SaltoTomado) begin
        // The wrong-path instructions in IF and ID are discarded; the front
        // end keeps fetching from the branch target.
        burbuja_ex  = 1'b1;
        vaciar_ifid = 1'b1;
      end else if ((estado_q == ST_MULT) || rcarga) begin
        // In MULT the load-use check is irrelevant: the front end is already
        // frozen, so both cases collapse to the same stall.
        esc_pc     = 1'b0;
        esc_ifid   = 1'b0;
        burbuja_ex = 1'b1;
      end
    end
  end

  // Next-state logic for the NORMAL/MULT machine.
  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;

    case (estado_q)
      ST_NORMAL: begin
        // A multiply is only accepted when it actually leaves ID: a load-use
        // stall keeps it there and a flush kills it.
        if (hz.MultIni && !hz.SaltoTomado && !rcarga) begin
          estado_d = ST_MULT;
          cuenta_d = CUENTA_INI;
        end
      end
      ST_MULT: begin
        // The multiplier keeps running through a flush; MultIni is ignored.
        cuenta_d = cuenta_q - 4'd1;
        if (cuenta_q == 4'd1) begin
          estado_d = ST_NORMAL;
        end
      end
      default: begin
        estado_d = ST_NORMAL;
        cuenta_d = 4'd0;
      end
    endcase
  end

  // Saturating stall-cycle counter.
  always_comb begin
    ciclos_paro_d = ciclos_paro_q;
    if (!esc_pc && (ciclos_paro_q != 16'hFFFF)) begin
      ciclos_paro_d = ciclos_paro_q + 16'd1;
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // is absent from the sensitivity list; state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q      <= ST_NORMAL;
      cuenta_q      <= 4'd0;
      ciclos_paro_q <= 16'd0;
    end else begin
      estado_q      <= estado_d;
      cuenta_q      <= cuenta_d;
      ciclos_paro_q <= ciclos_paro_d;
    end
  end

  assign hz.EscPC      = esc_pc;
  assign hz.EscIfId    = esc_ifid;
  assign hz.BurbujaEx  = burbuja_ex;
  assign hz.VaciarIfId = vaciar_ifid;
  assign hz.Ocupado    = ocupado;
  assign hz.CiclosParo = ciclos_paro_q;

endmodule
